// File: rtl/gray_conv_scheduler.sv
// Round-robin scheduler sharing one 4-bit Gray-to-binary converter among four requesters.
// One grant per pass through IDLE -> CAPT -> CONV -> HOLD; result on a valid/ready port.
module gray_conv_scheduler #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned TAG_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [4*N_REQ-1:0] gray_in,
    output logic [N_REQ-1:0]   ack,
    output logic [3:0]         bin_out,
    output logic [TAG_W-1:0]   bin_tag,
    output logic               bin_valid,
    input  logic               bin_ready,
    output logic               busy
);

    typedef enum logic [1:0] {
        StIdle,
        StCapt,
        StConv,
        StHold
    } state_e;

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   ptr_q, ptr_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [3:0]         gray_q, gray_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [3:0]         bin_q, bin_d;
    logic [TAG_W-1:0]   bin_tag_q, bin_tag_d;
    logic               valid_q, valid_d;

    logic               grant_valid;
    logic [TAG_W-1:0]   grant_idx;
    logic [TAG_W-1:0]   cand;

    // Each bit is the next-higher binary bit, inverted when the Gray bit is set.
    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = g[2] ? ~b[3] : b[3];
        b[1] = g[1] ? ~b[2] : b[2];
        b[0] = g[0] ? ~b[1] : b[1];
        return b;
    endfunction

    // First set request scanning upward from ptr; TAG_W-bit add wraps mod N_REQ.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = ptr_q + TAG_W'(off);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        tag_d     = tag_q;
        gray_d    = gray_q;
        ack_d     = '0;
        bin_d     = bin_q;
        bin_tag_d = bin_tag_q;
        valid_d   = valid_q;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    gray_d           = gray_in[{grant_idx, 2'b00} +: 4];
                    tag_d            = grant_idx;
                    ack_d[grant_idx] = 1'b1;
                    ptr_d            = grant_idx + TAG_W'(1);
                    state_d          = StCapt;
                end
            end
            StCapt: begin
                bin_d     = g2b(gray_q);
                bin_tag_d = tag_q;
                valid_d   = 1'b1;
                state_d   = StConv;
            end
            StConv: begin
                state_d = StHold;
            end
            StHold: begin
                if (bin_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            tag_q     <= '0;
            gray_q    <= '0;
            ack_q     <= '0;
            bin_q     <= '0;
            bin_tag_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            tag_q     <= tag_d;
            gray_q    <= gray_d;
            ack_q     <= ack_d;
            bin_q     <= bin_d;
            bin_tag_q <= bin_tag_d;
            valid_q   <= valid_d;
        end
    end

    assign ack       = ack_q;
    assign bin_out   = bin_q;
    assign bin_tag   = bin_tag_q;
    assign bin_valid = valid_q;
    assign busy      = (state_q != StIdle);

endmodule
